note_judge: RTL

//  Receiving end of the note spawn interface: consumes per-track spawn pulses and pitch from the

---
 rtl/note_judge.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/note_judge.sv
// -----------------------------------------------------------------------------
// note_judge
//
// Receives spawned notes from the note generator, queues them per track with
// their hit deadline and judges player presses against the head of each queue.
// Keeps score, combo and max combo. Forwards the pitch of every hit note to the
// buzzer.
//
// Ports
//   clk, rst          system clock, asynchronous active-high reset
//   i_cur_time        game time in ms (monotonic non-decreasing)
//   i_note_t1/_t2     1-cycle spawn pulses per track
//   i_gen_pitch       pitch of the spawned note, valid with a spawn pulse
//   i_btn_t1/_t2      1-cycle debounced presses per track
//   o_judge_valid     bit k-1 strobes a judgment for track k
//   o_judge_t1/_t2    3=PERFECT 2=GOOD 1=MISS 0=none
//   o_hit_pitch       pitch of the most recent hit note (track 1 wins a tie)
//   o_hit_strobe      1-cycle pulse when o_hit_pitch updates
//   o_score           accumulated score, saturating at 16'hFFFF
//   o_combo           consecutive hits, saturating at 255
//   o_max_combo       highest combo since reset
//   o_overflow        sticky flag: a spawn was dropped on a full queue
//
// Strobe semantics: every strobe output (o_judge_valid bits, o_hit_strobe) is
// high for exactly one cycle, one cycle after the input cycle that caused it.
// There is no back-pressure; a spawn on a full queue is dropped unless that
// queue pops in the same cycle.
// -----------------------------------------------------------------------------
module note_judge #(
  parameter int DEPTH       = 8,
  parameter int TRAVEL_MS   = 2000,
  parameter int PERFECT_WIN = 50,
  parameter int GOOD_WIN    = 150,
  parameter int PERFECT_PTS = 100,
  parameter int GOOD_PTS    = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_cur_time,
  input  logic        i_note_t1,
  input  logic        i_note_t2,
  input  logic [31:0] i_gen_pitch,
  input  logic        i_btn_t1,
  input  logic        i_btn_t2,
  output logic [1:0]  o_judge_valid,
  output logic [1:0]  o_judge_t1,
  output logic [1:0]  o_judge_t2,
  output logic [31:0] o_hit_pitch,
  output logic        o_hit_strobe,
  output logic [15:0] o_score,
  output logic [7:0]  o_combo,
  output logic [7:0]  o_max_combo,
  output logic        o_overflow
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    JUDGE_NONE    = 2'd0,
    JUDGE_MISS    = 2'd1,
    JUDGE_GOOD    = 2'd2,
    JUDGE_PERFECT = 2'd3
  } judge_e;

  typedef struct packed {
    logic [31:0] target;
    logic [31:0] pitch;
  } note_t;

  localparam logic [31:0] TRAVEL_W      = 32'(TRAVEL_MS);
  localparam logic [32:0] GOOD_WIN_W    = 33'(GOOD_WIN);
  localparam logic [32:0] PERFECT_WIN_W = 33'(PERFECT_WIN);
  localparam logic [17:0] PERFECT_ADD   = 18'(PERFECT_PTS);
  localparam logic [17:0] GOOD_ADD      = 18'(GOOD_PTS);

  // Per-track storage; the extra pointer bit distinguishes full from empty.
  note_t      mem    [2][DEPTH];
  logic [AW:0] rd_ptr [2];
  logic [AW:0] wr_ptr [2];

  logic [1:0]  spawn;
  logic [1:0]  btn;
  logic [1:0]  empty;
  logic [1:0]  full;
  logic [1:0]  expire;
  logic [1:0]  press_hit;
  logic [1:0]  perfect;
  logic [1:0]  pop;
  logic [1:0]  push;
  logic [1:0]  drop;
  note_t       head   [2];
  judge_e      judge  [2];
  logic [32:0] tgt_w  [2];
  logic [32:0] diff   [2];
  logic [32:0] cur_w;

  logic [17:0] add_pts;
  logic [17:0] score_sum;
  logic [15:0] score_next;
  logic [1:0]  hit_cnt;
  logic [8:0]  combo_sum;
  logic [7:0]  combo_next;
  logic [7:0]  max_next;

  assign spawn = {i_note_t2, i_note_t1};
  assign btn   = {i_btn_t2, i_btn_t1};
  // Widen to 33 bits so target+GOOD_WIN and time+GOOD_WIN never wrap.
  assign cur_w = {1'b0, i_cur_time};

  // Head evaluation per track: expiry has priority over a press.
  always_comb begin
    empty     = '0;
    full      = '0;
    expire    = '0;
    press_hit = '0;
    perfect   = '0;
    pop       = '0;
    push      = '0;
    drop      = '0;
    for (int k = 0; k < 2; k++) begin
      head[k]  = mem[k][rd_ptr[k][AW-1:0]];
      tgt_w[k] = {1'b0, head[k].target};
      diff[k]  = (cur_w >= tgt_w[k]) ? (cur_w - tgt_w[k]) : (tgt_w[k] - cur_w);
      judge[k] = JUDGE_NONE;

      empty[k] = (rd_ptr[k] == wr_ptr[k]);
      full[k]  = (rd_ptr[k][AW] != wr_ptr[k][AW]) &&
                 (rd_ptr[k][AW-1:0] == wr_ptr[k][AW-1:0]);

      expire[k]    = !empty[k] && (cur_w > (tgt_w[k] + GOOD_WIN_W));
      // A press that is too early, or on an empty queue, is simply ignored.
      press_hit[k] = btn[k] && !empty[k] && !expire[k] &&
                     ((cur_w + GOOD_WIN_W) >= tgt_w[k]);
      perfect[k]   = (diff[k] <= PERFECT_WIN_W);

      pop[k]  = expire[k] || press_hit[k];
      // A full queue can still take a spawn when its head leaves this cycle.
      push[k] = spawn[k] && (!full[k] || pop[k]);
      drop[k] = spawn[k] && full[k] && !pop[k];

      if (expire[k]) begin
        judge[k] = JUDGE_MISS;
      end else if (press_hit[k]) begin
        judge[k] = perfect[k] ? JUDGE_PERFECT : JUDGE_GOOD;
      end
    end
  end

  // Score and combo for this cycle; both tracks are summed before saturating.
  always_comb begin
    add_pts = '0;
    if (press_hit[0]) add_pts = add_pts + (perfect[0] ? PERFECT_ADD : GOOD_ADD);
    if (press_hit[1]) add_pts = add_pts + (perfect[1] ? PERFECT_ADD : GOOD_ADD);
    score_sum  = {2'b00, o_score} + add_pts;
    score_next = (score_sum > 18'h0FFFF) ? 16'hFFFF : score_sum[15:0];

    hit_cnt   = {1'b0, press_hit[0]} + {1'b0, press_hit[1]};
    combo_sum = {1'b0, o_combo} + {7'b0, hit_cnt};
    if (|expire) begin
      combo_next = 8'd0;
    end else if (combo_sum > 9'd255) begin
      combo_next = 8'hFF;
    end else begin
      combo_next = combo_sum[7:0];
    end
    max_next = (combo_next > o_max_combo) ? combo_next : o_max_combo;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_judge_valid <= '0;
      o_judge_t1    <= '0;
      o_judge_t2    <= '0;
      o_hit_pitch   <= '0;
      o_hit_strobe  <= 1'b0;
      o_score       <= '0;
      o_combo       <= '0;
      o_max_combo   <= '0;
      o_overflow    <= 1'b0;
      for (int k = 0; k < 2; k++) begin
        rd_ptr[k] <= '0;
        wr_ptr[k] <= '0;
      end
    end else begin
      o_judge_valid <= pop;
      o_judge_t1    <= judge[0];
      o_judge_t2    <= judge[1];
      o_hit_strobe  <= |press_hit;
      if (press_hit[0]) begin
        o_hit_pitch <= head[0].pitch;
      end else if (press_hit[1]) begin
        o_hit_pitch <= head[1].pitch;
      end
      o_score     <= score_next;
      o_combo     <= combo_next;
      o_max_combo <= max_next;
      if (|drop) o_overflow <= 1'b1;
      for (int k = 0; k < 2; k++) begin
        if (pop[k])  rd_ptr[k] <= rd_ptr[k] + {{AW{1'b0}}, 1'b1};
        if (push[k]) wr_ptr[k] <= wr_ptr[k] + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Queue contents need no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (push[k]) begin
        mem[k][wr_ptr[k][AW-1:0]] <= '{target: i_cur_time + TRAVEL_W,
                                        pitch:  i_gen_pitch};
      end
    end
  end

endmodule
